shift_operand_pipe: RTL and testbench

//  Parametrised, 2-stage pipelined operand-2 generator for the execute stage.
//  - Covers every ARM shifter form: rotated immediate, shift by immediate, shift by register (Rs), and memory offset.
//  - Also produces the shifter carry-out.
//  - Valid/ready handshake on both sides, so a stalled consumer back-pressures the producer without losing operands.

---
 rtl/shift_operand_pipe.sv | 198 +++++++++++++++++++
 tb/tb_shift_operand_pipe.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_operand_pipe.sv
// shift_operand_pipe: 2-stage ARM operand-2 generator with valid/ready handshake.
// Define SOP_CARRY_EN to compute carry_out and enable RRX on immediate ROR #0.
module shift_operand_pipe #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [DATA_W-1:0] val_rs,
    input  logic              imm,
    input  logic              mem_en,
    input  logic [11:0]       shift_operand,
    input  logic              c_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              carry_out
);
    localparam int LW = $clog2(DATA_W);
`ifdef SOP_CARRY_EN
    localparam logic CARRY_EN = 1'b1;
`else
    localparam logic CARRY_EN = 1'b0;
`endif
    localparam logic [SHAMT_W-1:0] C_WN = SHAMT_W'(DATA_W);
    localparam logic [LW:0]        C_W  = (LW+1)'(DATA_W);
    localparam logic [LW:0]        C_W1 = (LW+1)'(DATA_W + 1);

    typedef enum logic [1:0] {F_MEM, F_IMM, F_SIMM, F_SREG} form_t;
    typedef enum logic [1:0] {T_LSL, T_LSR, T_ASR, T_ROR} sh_t;

    // stage A state
    logic               r_a_valid;
    form_t              r_a_form;
    sh_t                r_a_typ;
    logic [DATA_W-1:0]  r_a_val;
    logic [SHAMT_W-1:0] r_a_amt;
    logic               r_a_cin;

    // stage B state
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_result;
    logic               r_carry;

    // decode / handshake wires
    form_t              w_d_form;
    sh_t                w_d_typ;
    logic [DATA_W-1:0]  w_d_val;
    logic [SHAMT_W-1:0] w_d_amt;
    logic               w_b_load;
    logic               w_a_adv;

    // shifter wires
    logic [LW:0]        w_lin_n;
    logic [LW:0]        w_asr_n;
    logic [LW-1:0]      w_k;
    logic [DATA_W:0]    w_lsl;
    logic [DATA_W:0]    w_lsr;
    logic [DATA_W:0]    w_asr;
    logic [DATA_W-1:0]  w_ror;
    logic               w_zero;
    logic [DATA_W-1:0]  w_res;
    logic               w_car;

    assign w_b_load  = !r_out_valid | out_ready;
    assign w_a_adv   = !r_a_valid | w_b_load;
    assign in_ready  = !flush & w_a_adv;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carry_out = r_carry;

    // decode the instruction form into value / amount / shift type
    always_comb begin
        w_d_form = F_SIMM;
        w_d_typ  = sh_t'(shift_operand[6:5]);
        w_d_val  = val_rm;
        w_d_amt  = SHAMT_W'(shift_operand[11:7]);
        if (mem_en) begin
            w_d_form = F_MEM;
            w_d_val  = DATA_W'(shift_operand);
        end else if (imm) begin
            w_d_form = F_IMM;
            w_d_typ  = T_ROR;
            w_d_val  = DATA_W'(shift_operand[7:0]);
            w_d_amt  = SHAMT_W'({shift_operand[11:8], 1'b0});
        end else if (shift_operand[4]) begin
            w_d_form = F_SREG;
            w_d_amt  = val_rs[SHAMT_W-1:0];
        end
    end

    // stage A: capture decoded fields whenever the stage can advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_valid <= 1'b0;
            r_a_form  <= F_MEM;
            r_a_typ   <= T_LSL;
            r_a_val   <= '0;
            r_a_amt   <= '0;
            r_a_cin   <= 1'b0;
        end else if (flush) begin
            r_a_valid <= 1'b0;
        end else if (w_a_adv) begin
            r_a_valid <= in_valid;
            if (in_valid) begin
                r_a_form <= w_d_form;
                r_a_typ  <= w_d_typ;
                r_a_val  <= w_d_val;
                r_a_amt  <= w_d_amt;
                r_a_cin  <= c_in;
            end
        end
    end

    // saturate counts so one barrel covers every amount; bit W / bit 0 is carry
    assign w_lin_n = (r_a_amt > C_WN) ? C_W1 : r_a_amt[LW:0];
    assign w_asr_n = (r_a_amt >= C_WN) ? C_W : r_a_amt[LW:0];
    assign w_k     = r_a_amt[LW-1:0];
    assign w_lsl   = {1'b0, r_a_val} << w_lin_n;
    assign w_lsr   = {r_a_val, 1'b0} >> w_lin_n;
    assign w_asr   = $signed({r_a_val, 1'b0}) >>> w_asr_n;
    assign w_ror   = (r_a_val >> w_k) | (r_a_val << (C_W - {1'b0, w_k}));
    assign w_zero  = (r_a_amt == '0);

    // select the operand and carry for the form held in stage A
    always_comb begin
        w_res = r_a_val;
        w_car = r_a_cin;
        unique case (r_a_form)
            F_MEM: ;
            F_IMM: begin
                w_res = w_ror;
                if (!w_zero) w_car = w_ror[DATA_W-1];
            end
            default: begin
                if (w_zero && r_a_form == F_SIMM) begin
                    unique case (r_a_typ)
                        T_LSL: ;
                        T_LSR: begin
                            w_res = '0;
                            w_car = r_a_val[DATA_W-1];
                        end
                        T_ASR: begin
                            w_res = {DATA_W{r_a_val[DATA_W-1]}};
                            w_car = r_a_val[DATA_W-1];
                        end
                        T_ROR: begin
                            if (CARRY_EN) begin
                                w_res = {r_a_cin, r_a_val[DATA_W-1:1]};
                                w_car = r_a_val[0];
                            end
                        end
                    endcase
                end else if (!w_zero) begin
                    unique case (r_a_typ)
                        T_LSL: begin
                            w_res = w_lsl[DATA_W-1:0];
                            w_car = w_lsl[DATA_W];
                        end
                        T_LSR: begin
                            w_res = w_lsr[DATA_W:1];
                            w_car = w_lsr[0];
                        end
                        T_ASR: begin
                            w_res = w_asr[DATA_W:1];
                            w_car = w_asr[0];
                        end
                        T_ROR: begin
                            w_res = w_ror;
                            w_car = w_ror[DATA_W-1];
                        end
                    endcase
                end
            end
        endcase
    end

    // stage B: register result/carry, hold them while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_b_load) begin
            r_out_valid <= r_a_valid;
            if (r_a_valid) begin
                r_result <= w_res;
                r_carry  <= CARRY_EN & w_car;
            end
        end
    end
endmodule

// File: tb/tb_shift_operand_pipe.sv
// tb_shift_operand_pipe: directed checks of shift_operand_pipe.
// Expected carries follow SOP_CARRY_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_shift_operand_pipe;
    localparam int W = 32;
`ifdef SOP_CARRY_EN
    localparam logic CEN = 1'b1;
`else
    localparam logic CEN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, imm, mem_en, c_in;
    logic         out_valid, out_ready, carry_out;
    logic [W-1:0] val_rm, val_rs, result;
    logic [11:0]  shift_operand;
    int           nvec = 0;
    int           nfail = 0;

    always #5 clk = ~clk;

    shift_operand_pipe #(.DATA_W(W), .SHAMT_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .val_rm(val_rm), .val_rs(val_rs), .imm(imm), .mem_en(mem_en),
        .shift_operand(shift_operand), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out)
    );

    task automatic run_op(input logic [W-1:0] rm, input logic [W-1:0] rs,
                          input logic im, input logic me,
                          input logic [11:0] op, input logic ci,
                          output logic [W-1:0] res, output logic car,
                          output int lat);
        int n;
        @(negedge clk);
        val_rm = rm; val_rs = rs; imm = im; mem_en = me;
        shift_operand = op; c_in = ci; out_ready = 1'b1; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk); #1; lat++;
        end
        res = result;
        car = carry_out;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        nvec++;
        if (out_valid !== 1'b0) begin
            nfail++; $display("FAIL reset out_valid: got %b want 0", out_valid);
        end
        nvec++;
        if (result !== '0) begin
            nfail++; $display("FAIL reset result: got %h want 0", result);
        end
        nvec++;
        if (carry_out !== 1'b0) begin
            nfail++; $display("FAIL reset carry: got %b want 0", carry_out);
        end
        rst = 1'b0;
        #1;
        nvec++;
        if (in_ready !== 1'b1) begin
            nfail++; $display("FAIL reset in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_imm();
        logic [11:0]  op [5] = '{12'h4FF, 12'h0AB, 12'h0AB, 12'h103, 12'hABC};
        logic         me [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic         ci [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] er [5] = '{32'hFF000000, 32'h000000AB, 32'h000000AB,
                                 32'hC0000000, 32'h00000ABC};
        logic         ec [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] res;
        logic         car;
        int           lat;
        for (int i = 0; i < 5; i++) begin
            run_op(32'hDEADBEEF, 32'h0, 1'b1, me[i], op[i], ci[i], res, car, lat);
            nvec++;
            if (res !== er[i]) begin
                nfail++; $display("FAIL imm[%0d] result: got %h want %h", i, res, er[i]);
            end
            nvec++;
            if (car !== (CEN & ec[i])) begin
                nfail++; $display("FAIL imm[%0d] carry: got %b want %b", i, car, CEN & ec[i]);
            end
            nvec++;
            if (lat != 2) begin
                nfail++; $display("FAIL imm[%0d] latency: got %0d want 2", i, lat);
            end
        end
    endtask

    task automatic test_reg_shift();
        logic [W-1:0] rm [8] = '{32'h80000001, 32'h80000001, 32'h1000000F, 32'h12345678,
                                 32'h00000003, 32'h80000001, 32'h000000AB, 32'h80000000};
        logic [W-1:0] rs [8] = '{32'd32, 32'd33, 32'd4, 32'h100,
                                 32'd1, 32'd32, 32'd8, 32'd40};
        logic [11:0]  op [8] = '{12'h010, 12'h010, 12'h010, 12'h010,
                                 12'h030, 12'h070, 12'h070, 12'h050};
        logic         ci [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [W-1:0] er [8] = '{32'h0, 32'h0, 32'h000000F0, 32'h12345678,
                                 32'h1, 32'h80000001, 32'hAB000000, 32'hFFFFFFFF};
        logic         ec [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [W-1:0] res;
        logic         car;
        int           lat;
        for (int i = 0; i < 8; i++) begin
            run_op(rm[i], rs[i], 1'b0, 1'b0, op[i], ci[i], res, car, lat);
            nvec++;
            if (res !== er[i]) begin
                nfail++; $display("FAIL reg[%0d] result: got %h want %h", i, res, er[i]);
            end
            nvec++;
            if (car !== (CEN & ec[i])) begin
                nfail++; $display("FAIL reg[%0d] carry: got %b want %b", i, car, CEN & ec[i]);
            end
        end
    endtask

    task automatic test_imm_shift();
        logic [W-1:0] rm [8] = '{32'h00000003, 32'h80000000, 32'h80000000, 32'h12345678,
                                 32'h12345678, 32'h80000000, 32'h8000000F, 32'h12345678};
        logic [11:0]  op [8] = '{12'h060, 12'h040, 12'h020, 12'h000,
                                 12'h200, 12'hFA0, 12'h240, 12'h260};
        logic         ci [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] er [8] = '{CEN ? 32'h80000001 : 32'h00000003, 32'hFFFFFFFF,
                                 32'h0, 32'h12345678, 32'h23456780, 32'h1,
                                 32'hF8000000, 32'h81234567};
        logic         ec [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] res;
        logic         car;
        int           lat;
        for (int i = 0; i < 8; i++) begin
            run_op(rm[i], 32'hFFFFFFFF, 1'b0, 1'b0, op[i], ci[i], res, car, lat);
            nvec++;
            if (res !== er[i]) begin
                nfail++; $display("FAIL shimm[%0d] result: got %h want %h", i, res, er[i]);
            end
            nvec++;
            if (car !== (CEN & ec[i])) begin
                nfail++; $display("FAIL shimm[%0d] carry: got %b want %b", i, car, CEN & ec[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got [$];
        int acc = 0;
        int acc_stall = 0;
        int cyc = 0;
        logic take, give;
        @(negedge clk);
        mem_en = 1'b1; imm = 1'b0; c_in = 1'b0;
        while ((acc < 4 || got.size() < 4) && cyc < 40) begin
            out_ready = (cyc >= 3);
            in_valid = (acc < 4);
            shift_operand = 12'h101 + 12'(acc);
            #1;
            if (cyc == 2) begin
                nvec++;
                if (in_ready !== 1'b0) begin
                    nfail++; $display("FAIL bp in_ready stall: got %b want 0", in_ready);
                end
                nvec++;
                if (result !== 32'h101) begin
                    nfail++; $display("FAIL bp stall result: got %h want 00000101", result);
                end
            end
            if (cyc == 3) begin
                nvec++;
                if (result !== 32'h101 || out_valid !== 1'b1) begin
                    nfail++;
                    $display("FAIL bp hold: got %h/%b want 00000101/1", result, out_valid);
                end
            end
            take = in_valid & in_ready;
            give = out_valid & out_ready;
            if (give) got.push_back(result);
            if (take) begin
                acc++;
                if (cyc < 3) acc_stall++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; mem_en = 1'b0;
        nvec++;
        if (acc_stall != 2) begin
            nfail++; $display("FAIL bp accepts while stalled: got %0d want 2", acc_stall);
        end
        nvec++;
        if (got.size() != 4) begin
            nfail++; $display("FAIL bp count: got %0d want 4", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            nvec++;
            if (got[i] !== 32'h101 + 32'(i)) begin
                nfail++; $display("FAIL bp order[%0d]: got %h want %h", i, got[i], 32'h101 + 32'(i));
            end
        end
        @(negedge clk); #1;
        nvec++;
        if (out_valid !== 1'b0) begin
            nfail++; $display("FAIL bp duplicate: got out_valid %b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        @(negedge clk);
        mem_en = 1'b1; imm = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; shift_operand = 12'h111;
        @(negedge clk);
        shift_operand = 12'h222;
        @(negedge clk);
        flush = 1'b1; shift_operand = 12'h333;
        #1;
        nvec++;
        if (in_ready !== 1'b0) begin
            nfail++; $display("FAIL flush in_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        nvec++;
        if (out_valid !== 1'b0) begin
            nfail++; $display("FAIL flush out_valid: got %b want 0", out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (out_valid) seen++;
        end
        nvec++;
        if (seen != 0) begin
            nfail++; $display("FAIL flush leftover outputs: got %0d want 0", seen);
        end
        mem_en = 1'b0;
    endtask

    task automatic test_rst_mid();
        int seen = 0;
        @(negedge clk);
        mem_en = 1'b1; imm = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; shift_operand = 12'h5A5;
        @(negedge clk);
        shift_operand = 12'h5A6;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        nvec++;
        if (out_valid !== 1'b1 || result !== 32'h5A5) begin
            nfail++; $display("FAIL rst pre: got %b/%h want 1/000005a5", out_valid, result);
        end
        #2 rst = 1'b1;
        #1;
        nvec++;
        if (out_valid !== 1'b0 || result !== '0 || carry_out !== 1'b0) begin
            nfail++;
            $display("FAIL rst async: got %b/%h/%b want 0/0/0", out_valid, result, carry_out);
        end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (out_valid) seen++;
        end
        nvec++;
        if (seen != 0) begin
            nfail++; $display("FAIL rst discard: got %0d outputs want 0", seen);
        end
        mem_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        val_rm = '0; val_rs = '0; imm = 1'b0; mem_en = 1'b0;
        shift_operand = '0; c_in = 1'b0;
        test_reset();
        test_imm();
        test_reg_shift();
        test_imm_shift();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
